// File: rtl/window_ctrl.sv
// Line-buffer controller for the conv front end: round-robin writes into four
// 3-tap line buffers and assembles registered 3x3 windows once three lines are held.
module window_ctrl #(
    parameter int F   = 28,
    parameter int B   = 8,
    parameter int NLB = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [B-1:0]       i_pixel_data,
    input  logic               i_pixel_valid,
    output logic               o_ready,
    input  logic               i_out_ready,
    input  logic [NLB*3*B-1:0] i_lb_data,
    output logic [NLB-1:0]     o_lb_wr_valid,
    output logic [NLB-1:0]     o_lb_rd,
    output logic [9*B-1:0]     o_pixel_data,
    output logic               o_pixel_valid,
    output logic               o_intr
);

    localparam int CW    = (F > 1) ? $clog2(F) : 1;
    localparam int SW    = $clog2(NLB);
    localparam int OW    = $clog2(NLB*F + 1);
    localparam logic [CW-1:0] LAST   = CW'(F - 1);
    localparam logic [OW-1:0] FULL   = OW'(NLB*F);
    localparam logic [OW-1:0] THRESH = OW'(3*F);

    typedef enum logic {IDLE, READ} state_t;

    state_t          state;
    logic [CW-1:0]   wr_cnt;
    logic [SW-1:0]   wr_sel;
    logic [CW-1:0]   rd_cnt;
    logic [SW-1:0]   rd_sel;
    logic [OW-1:0]   occupancy;
    logic            accept;
    logic            rd_fire;
    logic [SW-1:0]   sel1;
    logic [SW-1:0]   sel2;
    logic [9*B-1:0]  window;

    assign o_ready = (occupancy < FULL);

    always_comb begin
        accept        = i_pixel_valid & o_ready;
        rd_fire       = (state == READ) & i_out_ready;
        sel1          = rd_sel + SW'(1);
        sel2          = rd_sel + SW'(2);
        o_lb_wr_valid = '0;
        o_lb_rd       = '0;
        if (accept) begin
            o_lb_wr_valid[wr_sel] = 1'b1;
        end
        if (rd_fire) begin
            o_lb_rd[rd_sel] = 1'b1;
            o_lb_rd[sel1]   = 1'b1;
            o_lb_rd[sel2]   = 1'b1;
        end
        // Top row comes from the oldest buffer still held, bottom from the newest.
        window = {i_lb_data[int'(rd_sel)*3*B +: 3*B],
                  i_lb_data[int'(sel1)*3*B   +: 3*B],
                  i_lb_data[int'(sel2)*3*B   +: 3*B]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt    <= '0;
            wr_sel    <= '0;
            occupancy <= '0;
        end else begin
            if (accept) begin
                if (wr_cnt == LAST) begin
                    wr_cnt <= '0;
                    wr_sel <= wr_sel + SW'(1);
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end
            case ({accept, rd_fire})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Returning to IDLE after each row forces a one-cycle gap between output rows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            rd_sel        <= '0;
            o_intr        <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_pixel_data  <= '0;
        end else begin
            o_intr        <= 1'b0;
            o_pixel_valid <= rd_fire;
            if (rd_fire) begin
                o_pixel_data <= window;
            end
            case (state)
                IDLE: begin
                    if (occupancy >= THRESH) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_fire) begin
                        if (rd_cnt == LAST) begin
                            rd_cnt <= '0;
                            rd_sel <= rd_sel + SW'(1);
                            o_intr <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_ctrl.sv
// Bench for window_ctrl: behavioural line buffers feed the DUT, and a scoreboard
// built from the accepted pixel stream checks every 3x3 window it emits.
module tb_window_ctrl;

    localparam int F     = 28;
    localparam int B     = 8;
    localparam int NLB   = 4;
    localparam int DEPTH = NLB*F;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [B-1:0]       i_pixel_data;
    logic               i_pixel_valid;
    logic               o_ready;
    logic               i_out_ready;
    logic [NLB*3*B-1:0] i_lb_data;
    logic [NLB-1:0]     o_lb_wr_valid;
    logic [NLB-1:0]     o_lb_rd;
    logic [9*B-1:0]     o_pixel_data;
    logic               o_pixel_valid;
    logic               o_intr;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    window_ctrl #(.F(F), .B(B), .NLB(NLB)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pixel_data  (i_pixel_data),
        .i_pixel_valid (i_pixel_valid),
        .o_ready       (o_ready),
        .i_out_ready   (i_out_ready),
        .i_lb_data     (i_lb_data),
        .o_lb_wr_valid (o_lb_wr_valid),
        .o_lb_rd       (o_lb_rd),
        .o_pixel_data  (o_pixel_data),
        .o_pixel_valid (o_pixel_valid),
        .o_intr        (o_intr)
    );

    // Line buffers: a line of storage each, 3-pixel tap at the read pointer, zero past the right edge.
    logic [B-1:0] lb_mem [NLB][F];
    int           lb_wp  [NLB];
    int           lb_rp  [NLB];

    initial begin
        for (int k = 0; k < NLB; k++) begin
            lb_wp[k] = 0;
            lb_rp[k] = 0;
            for (int c = 0; c < F; c++) lb_mem[k][c] = '0;
        end
    end

    always @(posedge i_clk) begin
        for (int k = 0; k < NLB; k++) begin
            if (i_rst) begin
                lb_wp[k] <= 0;
                lb_rp[k] <= 0;
            end else begin
                if (o_lb_wr_valid[k]) begin
                    lb_mem[k][lb_wp[k]] <= i_pixel_data;
                    lb_wp[k] <= (lb_wp[k] == F-1) ? 0 : lb_wp[k] + 1;
                end
                if (o_lb_rd[k]) lb_rp[k] <= (lb_rp[k] == F-1) ? 0 : lb_rp[k] + 1;
            end
        end
    end

    always_comb begin
        i_lb_data = '0;
        for (int k = 0; k < NLB; k++)
            for (int j = 0; j < 3; j++)
                if (lb_rp[k] + j < F) i_lb_data[k*3*B + (2-j)*B +: B] = lb_mem[k][lb_rp[k] + j];
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: raster history of accepted pixels, windows derived by row/column arithmetic.
    logic [B-1:0]   pix_hist[$];
    logic [9*B-1:0] exp_q[$];
    int             acc_count = 0;
    int             fires     = 0;
    int             occ_m     = 0;
    bit             exp_intr  = 0;

    function automatic logic [B-1:0] pix(input int line, input int col);
        if (col >= F) return '0;
        return pix_hist[line*F + col];
    endfunction

    function automatic logic [3*B-1:0] row_slice(input int line, input int col);
        return {pix(line, col), pix(line, col+1), pix(line, col+2)};
    endfunction

    always @(negedge i_clk) begin : model
        bit             acc;
        bit             fire;
        int             row;
        logic [NLB-1:0] exp_wr;
        logic [NLB-1:0] exp_rd;
        if (i_rst) begin
            pix_hist.delete();
            exp_q.delete();
            acc_count = 0;
            fires     = 0;
            occ_m     = 0;
            exp_intr  = 0;
        end else begin
            checkOutput("ready", o_ready, occ_m < DEPTH);
            acc    = i_pixel_valid && (occ_m < DEPTH);
            exp_wr = acc ? NLB'(1 << ((acc_count / F) % NLB)) : '0;
            checkOutput("wr_valid", o_lb_wr_valid, exp_wr);
            checkOutput("intr", o_intr, exp_intr);
            fire = (o_lb_rd != '0);
            if (fire) begin
                row    = fires / F;
                exp_rd = '0;
                if (i_out_ready && acc_count >= (row + 3) * F)
                    for (int j = 0; j < 3; j++) exp_rd[(row + j) % NLB] = 1'b1;
                checkOutput("lb_rd", o_lb_rd, exp_rd);
            end
            exp_intr = fire && ((fires + 1) % F == 0);
            if (acc) begin
                pix_hist.push_back(i_pixel_data);
                acc_count++;
                if (acc_count % F == 0 && acc_count >= 3*F) begin
                    row = acc_count / F - 3;
                    for (int c = 0; c < F; c++)
                        exp_q.push_back({row_slice(row, c), row_slice(row+1, c), row_slice(row+2, c)});
                end
            end
            fires = fires + int'(fire);
            occ_m = occ_m + int'(acc) - int'(fire);
        end
    end

    logic [9*B-1:0] last_data = '0;

    always @(negedge i_clk) begin : monitor
        logic [9*B-1:0] exp;
        if (i_rst) begin
            last_data = '0;
        end else if (o_pixel_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("window_unexpected", o_pixel_valid, 1'b0);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("window", o_pixel_data, exp);
                last_data = exp;
            end
        end else begin
            checkOutput("hold", o_pixel_data, last_data);
        end
    end

    task automatic applyStimulus(input bit v, input logic [B-1:0] d, input bit rdy);
        @(posedge i_clk);
        #1;
        i_pixel_valid = v;
        i_pixel_data  = d;
        i_out_ready   = rdy;
    endtask

    task automatic doReset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        i_pixel_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        bit seen;
        i_rst = 1'b1;
        i_pixel_valid = 1'b0;
        i_pixel_data  = '0;
        i_out_ready   = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_valid", o_pixel_valid, 1'b0);
        checkOutput("rst_data", o_pixel_data, '0);
        checkOutput("rst_intr", o_intr, 1'b0);
        checkOutput("rst_ready", o_ready, 1'b1);
        checkOutput("rst_rd", o_lb_rd, '0);

        // Three lines 1..84, then the first row is read out.
        for (int i = 1; i <= 3*F; i++) applyStimulus(1'b1, B'(i), 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("rd_early", o_lb_rd, '0);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("first_rd", o_lb_rd, 4'b0111);
        checkOutput("first_top", i_lb_data[0 +: 3*B], {8'd1, 8'd2, 8'd3});
        repeat (40) applyStimulus(1'b0, '0, 1'b1);

        // Continuous streaming so the read selector wraps past buffer 3.
        for (int i = 0; i < 5*F; i++) applyStimulus(1'b1, B'(3*F + 1 + i), 1'b1);
        repeat (150) applyStimulus(1'b0, '0, 1'b1);

        // Fill to capacity with no reads; the 113th pixel must be dropped.
        doReset();
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, B'($urandom), 1'b0);
        @(negedge i_clk);
        checkOutput("full_ready", o_ready, 1'b0);
        repeat (150) applyStimulus(1'b0, '0, 1'b1);

        // Random traffic with stalls and simultaneous accept/read.
        doReset();
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 99) < 70, B'($urandom), $urandom_range(0, 99) < 60);
        repeat (150) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain", 32'(exp_q.size()), '0);

        // Reset while a row is being read out.
        doReset();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            applyStimulus(1'b1, B'($urandom), 1'b1);
            seen = o_pixel_valid;
        end
        checkOutput("reach_read", seen, 1'b1);
        repeat (9) applyStimulus(1'b0, '0, 1'b1);
        doReset();
        @(negedge i_clk);
        checkOutput("midrst_valid", o_pixel_valid, 1'b0);
        checkOutput("midrst_ready", o_ready, 1'b1);
        checkOutput("midrst_intr", o_intr, 1'b0);
        repeat (40) applyStimulus(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
